// File: rtl/bp_pkg.sv
// Shared types, counter encodings and helpers for the branch predictor.
package bp_pkg;

  // Control-flow class resolved in EX; CALL is stored in the BTB as JMP.
  typedef enum logic [1:0] {
    BR   = 2'd0,
    JMP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } cf_type_e;

  localparam int unsigned CTR_W = 2;

  // 2-bit saturating counter encodings.
  localparam logic [CTR_W-1:0] SNT = 2'b00;
  localparam logic [CTR_W-1:0] WNT = 2'b01;
  localparam logic [CTR_W-1:0] WT  = 2'b10;
  localparam logic [CTR_W-1:0] ST  = 2'b11;

  // Resettable per-entry state; tag and target live in separate non-reset arrays.
  typedef struct packed {
    logic             valid;
    cf_type_e         typ;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                  input logic taken);
    logic [CTR_W-1:0] res;
    res = ctr;
    if (taken && ctr != ST) begin
      res = ctr + 2'd1;
    end else if (!taken && ctr != SNT) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bp_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  stack_q [RAS_DEPTH];
  logic [XLEN-1:0]  stack_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next write slot; the top of stack sits just below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = stack_q[top_idx];
  assign empty_o = (cnt_q == '0);

  // Next-state for pointer, occupancy and storage.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (push_i) begin
      stack_d[ptr_q] = push_data_i;
      ptr_d          = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and count are reset; storage contents are don't-care when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage register.
  always_ff @(posedge clk_i) begin
    stack_q <= stack_d;
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with 2-bit counters, RAS and EX-stage mispredict detection.
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_hit_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  cf_type_e         ex_type_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pred_target_i,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] perf_lookups_o,
  output logic [CNT_W-1:0] perf_mispred_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  btb_entry_t       meta_q [ENTRIES];
  btb_entry_t       meta_d [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [TAG_W-1:0] tag_d  [ENTRIES];
  logic [XLEN-1:0]  tgt_q  [ENTRIES];
  logic [XLEN-1:0]  tgt_d  [ENTRIES];

  logic [CNT_W-1:0] lookups_q, lookups_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       if_entry;
  logic             ex_hit;
  logic [XLEN-1:0]  if_pc_plus4, ex_pc_plus4;
  logic [XLEN-1:0]  actual_next, pred_next;
  logic             ras_push, ras_pop, ras_empty;
  logic [XLEN-1:0]  ras_top;

  assign if_idx      = if_pc_i[IDX_W+1:2];
  assign if_tag      = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx      = ex_pc_i[IDX_W+1:2];
  assign ex_tag      = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign if_pc_plus4 = if_pc_i + XLEN'(4);
  assign ex_pc_plus4 = ex_pc_i + XLEN'(4);
  assign if_entry    = meta_q[if_idx];
  assign ex_hit      = meta_q[ex_idx].valid && (tag_q[ex_idx] == ex_tag);

  // IF lookup reads registered state only, so a same-cycle update is not visible.
  always_comb begin
    pred_hit_o    = if_entry.valid && (tag_q[if_idx] == if_tag);
    pred_taken_o  = pred_hit_o && ((if_entry.typ != BR) || if_entry.ctr[1]);
    pred_target_o = if_pc_plus4;
    if (pred_taken_o) begin
      if (if_entry.typ == RET && !ras_empty) begin
        pred_target_o = ras_top;
      end else begin
        pred_target_o = tgt_q[if_idx];
      end
    end
  end

  // EX resolution: compare the next PC actually taken against the one predicted.
  always_comb begin
    actual_next   = ex_taken_i      ? ex_target_i      : ex_pc_plus4;
    pred_next     = ex_pred_taken_i ? ex_pred_target_i : ex_pc_plus4;
    mispredict_o  = ex_valid_i && (actual_next != pred_next);
    redirect_pc_o = actual_next;
  end

  // BTB training: counter/target refresh on hit, allocation on taken miss.
  always_comb begin
    meta_d = meta_q;
    tag_d  = tag_q;
    tgt_d  = tgt_q;
    if (ex_valid_i) begin
      if (ex_hit) begin
        if (meta_q[ex_idx].typ == BR) begin
          meta_d[ex_idx].ctr = sat_update(meta_q[ex_idx].ctr, ex_taken_i);
        end
        if (ex_taken_i) begin
          tgt_d[ex_idx] = ex_target_i;
        end
      end else if (ex_taken_i) begin
        meta_d[ex_idx].valid = 1'b1;
        tag_d[ex_idx]        = ex_tag;
        tgt_d[ex_idx]        = ex_target_i;
        if (ex_type_i == CALL) begin
          meta_d[ex_idx].typ = JMP;
        end else begin
          meta_d[ex_idx].typ = ex_type_i;
        end
        if (ex_type_i == BR) begin
          meta_d[ex_idx].ctr = WT;
        end else begin
          meta_d[ex_idx].ctr = ST;
        end
      end
    end
  end

  // Performance counter next-state; both wrap naturally.
  always_comb begin
    lookups_d = lookups_q;
    mispred_d = mispred_q;
    if (ex_valid_i) begin
      lookups_d = lookups_q + CNT_W'(1);
    end
    if (mispredict_o) begin
      mispred_d = mispred_q + CNT_W'(1);
    end
  end

  // Resettable state: entry metadata and perf counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        meta_q[i] <= '0;
      end
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      meta_q    <= meta_d;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  // Tag and target arrays are qualified by valid, so they are not reset.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign perf_lookups_o = lookups_q;
  assign perf_mispred_o = mispred_q;

  assign ras_push = ex_valid_i && (ex_type_i == CALL);
  assign ras_pop  = ex_valid_i && (ex_type_i == RET);

  bp_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (ex_pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit with default parameters.
module tb_branch_predictor_unit;
  import bp_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  cf_type_e    ex_type;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_lookups, perf_mispred;

  int errors = 0;
  int checks = 0;
  int exp_lookups = 0;
  int exp_mispred = 0;

  branch_predictor_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_pc_i          (if_pc),
    .pred_hit_o       (pred_hit),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_pc_i          (ex_pc),
    .ex_type_i        (ex_type),
    .ex_taken_i       (ex_taken),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .mispredict_o     (mispredict),
    .redirect_pc_o    (redirect_pc),
    .perf_lookups_o   (perf_lookups),
    .perf_mispred_o   (perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One EX resolution predicted not-taken; called one step after a rising edge.
  task automatic do_ex(input logic [31:0] pc, input cf_type_e ty, input logic tk,
                       input logic [31:0] tgt);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_type        = ty;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    exp_lookups++;
    if (tk && tgt != pc + 32'd4) exp_mispred++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    if_pc = 32'h100;
    #2;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_target got=%h exp=104", pred_target); end
    checks++; if (perf_lookups !== 32'd0) begin errors++; $display("FAIL reset_lookups got=%0d exp=0", perf_lookups); end
    checks++; if (perf_mispred !== 32'd0) begin errors++; $display("FAIL reset_mispred got=%0d exp=0", perf_mispred); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alloc();
    do_ex(32'h180, BR, 1'b0, 32'h80);
    if_pc = 32'h180; #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_no_alloc got=%b exp=0", pred_hit); end
    do_ex(32'h100, BR, 1'b1, 32'h80);
    if_pc = 32'h100; #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got=%b exp=1", pred_hit); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken got=%b exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alloc_target got=%h exp=80", pred_target); end
  endtask

  task automatic test_hysteresis();
    // Start at WT; each step: outcome, expected prediction afterwards.
    logic tk_seq  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_seq [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_tgt;
    for (int i = 0; i < 8; i++) begin
      do_ex(32'h100, BR, tk_seq[i], 32'h80);
      if_pc = 32'h100; #1;
      exp_tgt = exp_seq[i] ? 32'h80 : 32'h104;
      checks++;
      if (pred_taken !== exp_seq[i] || pred_target !== exp_tgt) begin
        errors++;
        $display("FAIL hyst_step%0d got taken=%b tgt=%h exp taken=%b tgt=%h",
                 i, pred_taken, pred_target, exp_seq[i], exp_tgt);
      end
    end
  endtask

  task automatic test_alias();
    if_pc = 32'h4100; #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alias_hit got=%b exp=1", pred_hit); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alias_target got=%h exp=80", pred_target); end
    if_pc = 32'h140; #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL tag_miss_hit got=%b exp=0", pred_hit); end
    checks++; if (pred_target !== 32'h144) begin errors++; $display("FAIL tag_miss_target got=%h exp=144", pred_target); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_tgt;
    do_ex(32'h300, RET, 1'b1, 32'h700);
    if_pc = 32'h300; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h700) begin errors++; $display("FAIL ret_empty got taken=%b tgt=%h exp taken=1 tgt=700", pred_taken, pred_target); end
    do_ex(32'h204, CALL, 1'b1, 32'h1000);
    if_pc = 32'h300; #1;
    checks++; if (pred_target !== 32'h208) begin errors++; $display("FAIL ret_top got=%h exp=208", pred_target); end
    if_pc = 32'h204; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h1000) begin errors++; $display("FAIL call_as_jmp got taken=%b tgt=%h exp taken=1 tgt=1000", pred_taken, pred_target); end
    do_ex(32'h300, RET, 1'b1, 32'h700);
    if_pc = 32'h300; #1;
    checks++; if (pred_target !== 32'h700) begin errors++; $display("FAIL ret_after_pop got=%h exp=700", pred_target); end
    for (int i = 0; i < 5; i++) begin
      do_ex(32'h204 + 32'(4 * i), CALL, 1'b1, 32'h1000);
    end
    for (int k = 0; k < 5; k++) begin
      if_pc = 32'h300; #1;
      exp_tgt = (k < 4) ? 32'h218 - 32'(4 * k) : 32'h700;
      checks++;
      if (pred_target !== exp_tgt) begin
        errors++;
        $display("FAIL ras_pop%0d got=%h exp=%h", k, pred_target, exp_tgt);
      end
      do_ex(32'h300, RET, 1'b1, 32'h700);
    end
    checks++; if (perf_lookups !== 32'(exp_lookups)) begin errors++; $display("FAIL perf_lookups got=%0d exp=%0d", perf_lookups, exp_lookups); end
    checks++; if (perf_mispred !== 32'(exp_mispred)) begin errors++; $display("FAIL perf_mispred got=%0d exp=%0d", perf_mispred, exp_mispred); end
  endtask

  task automatic test_mispredict();
    ex_valid       = 1'b0;
    ex_pc          = 32'h100;
    ex_type        = BR;
    ex_taken       = 1'b0;
    ex_target      = 32'h80;
    ex_pred_taken  = 1'b1;
    ex_pred_target = 32'h80;
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mp_gated got=%b exp=0", mispredict); end
    ex_valid = 1'b1; #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL mp_flag got=%b exp=1", mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL mp_redirect got=%h exp=104", redirect_pc); end
    ex_taken = 1'b1; #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mp_correct got=%b exp=0", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL mp_correct_redirect got=%h exp=80", redirect_pc); end
    ex_taken = 1'b0;
    @(posedge clk); #1;
    exp_lookups++;
    exp_mispred++;
    checks++; if (perf_mispred !== 32'(exp_mispred)) begin errors++; $display("FAIL mp_count got=%0d exp=%0d", perf_mispred, exp_mispred); end
    checks++; if (perf_lookups !== 32'(exp_lookups)) begin errors++; $display("FAIL mp_lookups got=%0d exp=%0d", perf_lookups, exp_lookups); end
    // Same mispredicting resolution, with reset raised mid-cycle.
    if_pc = 32'h300;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (perf_lookups !== 32'd0 || perf_mispred !== 32'd0) begin errors++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_lookups, perf_mispred); end
    checks++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin errors++; $display("FAIL rst_btb got hit=%b taken=%b exp 0/0", pred_hit, pred_taken); end
    checks++; if (pred_target !== 32'h304) begin errors++; $display("FAIL rst_target got=%h exp=304", pred_target); end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    if_pc = 32'h204; #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL post_rst_hit got=%b exp=0", pred_hit); end
    checks++; if (perf_lookups !== 32'd0) begin errors++; $display("FAIL post_rst_lookups got=%0d exp=0", perf_lookups); end
  endtask

  initial begin
    rst            = 1'b1;
    if_pc          = 32'h0;
    ex_valid       = 1'b0;
    ex_pc          = 32'h0;
    ex_type        = BR;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    test_reset();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_ras();
    test_mispredict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Parametrised successor to the fixed 16-entry, 4-bit-tag BTB with hit comparator used in the 5-stage pipeline.
- Provides a direct-mapped BTB with configurable depth and tag width, per-entry 2-bit saturating counters, entry typing (branch/jump/return), a return-address stack (RAS) and mispredict detection.
- Lookup is combinational in IF; update and mispredict resolution happen in EX.

Parameters:
XLEN, 32, data/address width
ENTRIES, 16, BTB entries; power of 2, ≥2; IDX_W = log2(ENTRIES)
TAG_W, 8, tag bits; requires IDX_W+TAG_W+2 ≤ XLEN
RAS_DEPTH, 4, RAS entries; power of 2, ≥2
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; asynchronous, active-high
if_pc_i  in  XLEN  fetch PC
pred_hit_o  out  1  valid BTB entry matches if_pc_i
pred_taken_o  out  1  predict redirect
pred_target_o  out  XLEN  predicted next PC
ex_valid_i  in  1  control-flow instruction resolved in EX this cycle
ex_pc_i  in  XLEN  PC of resolved instruction
ex_type_i  in  2  bp_pkg::cf_type_e: BR, JMP, CALL, RET
ex_taken_i  in  1  actual direction; 1 for JMP/CALL/RET
ex_target_i  in  XLEN  actual target
ex_pred_taken_i  in  1  prediction carried down the pipe from IF
ex_pred_target_i  in  XLEN  predicted target carried down the pipe
mispredict_o  out  1  flush IF/ID and ID/EX
redirect_pc_o  out  XLEN  correct next PC
perf_lookups_o  out  CNT_W  EX resolutions counted
perf_mispred_o  out  CNT_W  mispredicts counted

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, target, type (BR, JMP, RET), 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup is combinational, zero-latency:
  - pred_hit_o = valid & tag match.
  - pred_taken_o = hit & (type≠BR | ctr[1]).
  - pred_target_o = if_pc_i+4 when not taken.
  - RET entry with RAS non-empty → RAS top.
  - RET entry with RAS empty → stored target.
  - Otherwise → stored target.
- Mispredict logic is combinational and gated by ex_valid_i:
  - actual_next = ex_taken_i ? ex_target_i : ex_pc_i+4.
  - pred_next = ex_pred_taken_i ? ex_pred_target_i : ex_pc_i+4.
  - mispredict_o = ex_valid_i & (actual_next ≠ pred_next).
  - redirect_pc_o = actual_next.
  - mispredict_o = 0 whenever ex_valid_i = 0.
- BTB update at the clock edge when ex_valid_i:
  - Hit, type BR: counter saturating increment if taken, decrement if not; 11+1 stays 11, 00−1 stays 00.
  - Hit: target rewritten with ex_target_i when taken.
  - Miss, taken: allocate (overwrite victim at index).
    - valid = 1, tag, target, type (CALL stored as JMP).
    - Counter = 10 for BR, 11 otherwise.
  - Miss, not taken: no allocation.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write).
- RAS is updated at the EX edge when ex_valid_i:
  - CALL pushes ex_pc_i+4.
  - RET pops.
  - Full push: overwrite oldest (circular pointer); count saturates at RAS_DEPTH.
  - Empty pop: no-op; count stays 0.
- Perf counters: perf_lookups_o increments on ex_valid_i; perf_mispred_o increments on mispredict_o. Both wrap modulo 2^CNT_W.
- Reset (async assert, any cycle, including mid-update) clears:
  - all valid bits, counters and type fields;
  - RAS pointer and count;
  - perf counters.
  - Target/tag arrays need not be cleared.
- Post-reset outputs: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = if_pc_i+4, perf_* = 0.

Decomposition:
- bp_pkg:
  - cf_type_e {BR, JMP, CALL, RET}
  - counter encoding constants SNT/WNT/WT/ST
  - btb_entry_t struct (parametrised via localparam widths)
  - sat_update function
- Sub-module bp_ras:
  - circular stack with push/pop/top/empty;
  - parameters XLEN, RAS_DEPTH;
  - same clk_i/rst_i.

Test Plan:
- Reset then if_pc_i=0x100 → pred_hit_o=0, pred_taken_o=0, pred_target_o=0x104; perf counters 0.
- Taken BR miss: ex_pc=0x100, target=0x80, allocated → next cycle if_pc=0x100 gives hit=1, taken=1, target=0x80.
- Counter hysteresis: after allocation (WT), two not-taken resolutions → counter 00, prediction not-taken. One taken → 01, still not-taken. Second taken → 10, taken.
- Aliasing: ENTRIES=16, 0x100 allocated, lookup 0x100+(16<<2)·(1<<TAG_W) hits; 0x140 with same index but different tag → hit=0.
- RAS: CALL at 0x200 (push 0x204) and RET entry at 0x300 → lookup 0x300 target=0x204. Five CALLs with RAS_DEPTH=4 then four RETs return the last four return addresses; a fifth RET with empty RAS uses the stored target.
- Mispredict: ex_pred_taken=1/target 0x80, actual not-taken at ex_pc 0x100 → mispredict_o=1, redirect_pc_o=0x104, perf_mispred_o increments. Assert rst_i the same cycle → all state cleared before the next edge.
